// File: rtl/rtsnoc_local_port_arbiter_if.sv
// Bridge-side and router-side signals of the shared RTSNoC local port, flattened per requester.
// The slave modport is the arbiter's view; the master modport is the environment driving it.
interface rtsnoc_local_port_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int BUS     = 42
);
  logic [NUM_REQ*BUS-1:0] req_din_i;
  logic [NUM_REQ-1:0]     req_wr_i;
  logic [NUM_REQ-1:0]     req_wait_o;
  logic [NUM_REQ*BUS-1:0] rx_dout_o;
  logic [NUM_REQ-1:0]     rx_nd_o;
  logic [NUM_REQ-1:0]     rx_rd_i;
  logic [BUS-1:0]         noc_din_o;
  logic                   noc_wr_o;
  logic                   noc_wait_i;
  logic [BUS-1:0]         noc_dout_i;
  logic                   noc_nd_i;
  logic                   noc_rd_o;
  logic [15:0]            stat_tx_cnt_o;
  logic [15:0]            stat_drop_cnt_o;

  modport slave (
    input  req_din_i, req_wr_i, rx_rd_i, noc_wait_i, noc_dout_i, noc_nd_i,
    output req_wait_o, rx_dout_o, rx_nd_o, noc_din_o, noc_wr_o, noc_rd_o,
           stat_tx_cnt_o, stat_drop_cnt_o
  );

  modport master (
    output req_din_i, req_wr_i, rx_rd_i, noc_wait_i, noc_dout_i, noc_nd_i,
    input  req_wait_o, rx_dout_o, rx_nd_o, noc_din_o, noc_wr_o, noc_rd_o,
           stat_tx_cnt_o, stat_drop_cnt_o
  );
endinterface

// File: rtl/rtsnoc_local_port_arbiter.sv
// Round-robin TX arbiter and H_ORIG-routed RX demux sharing one RTSNoC local port; req_wr to noc_wr is 1 cycle.
// Router wait stalls grants, full RX holding register stalls pops; RTSNOC_ARB_STATS_EN builds the stats counters.
module rtsnoc_local_port_arbiter #(
  parameter int          NUM_REQ        = 4,
  parameter int          NOC_DATA_WIDTH = 32,
  parameter int          SOC_SIZE_X     = 1,
  parameter int          SOC_SIZE_Y     = 1,
  parameter logic [23:0] REQ_TGT_ADR    = 24'h0
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  rtsnoc_local_port_arbiter_if.slave   bus
);
  localparam int HDR    = 2*SOC_SIZE_X + 2*SOC_SIZE_Y + 6;
  localparam int BUS    = NOC_DATA_WIDTH + HDR;
  localparam int HO_MSB = BUS - 1 - SOC_SIZE_X - SOC_SIZE_Y;
  localparam int RRW    = $clog2(NUM_REQ);

  localparam logic [0:0] TX_IDLE = 1'b0;
  localparam logic [0:0] TX_SEND = 1'b1;
  localparam logic [0:0] RX_IDLE = 1'b0;
  localparam logic [0:0] RX_GAP  = 1'b1;

  logic [0:0]             tx_state_q, tx_state_d;
  logic [RRW-1:0]         rr_q, rr_d;
  logic [BUS-1:0]         noc_din_q, noc_din_d;
  logic [NUM_REQ-1:0]     grant_oh;
  logic                   tx_open;

  logic [0:0]             rx_state_q, rx_state_d;
  logic [NUM_REQ-1:0]     rx_nd_q, rx_nd_d;
  logic [NUM_REQ*BUS-1:0] rx_dout_q, rx_dout_d;
  logic [NUM_REQ-1:0]     match_oh;
  logic [2:0]             h_orig;
  logic                   rx_free;
  logic                   noc_rd;

  // Grants only when the port can take a flit this cycle: idle, or the held flit leaves now.
  always_comb begin
    tx_state_d = tx_state_q;
    rr_d       = rr_q;
    noc_din_d  = noc_din_q;
    grant_oh   = '0;
    tx_open    = rst_n_i && ((tx_state_q == TX_IDLE) || !bus.noc_wait_i);
    if (tx_open) begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (bus.req_wr_i[i] && ((int'(rr_q) + k == i) || (int'(rr_q) + k == i + NUM_REQ))) begin
            grant_oh    = '0;
            grant_oh[i] = 1'b1;
          end
        end
      end
      tx_state_d = (grant_oh != '0) ? TX_SEND : TX_IDLE;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_oh[i]) begin
          noc_din_d = bus.req_din_i[BUS*i +: BUS];
          rr_d      = RRW'(i);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_state_q <= TX_IDLE;
      rr_q       <= RRW'(NUM_REQ - 1);
      noc_din_q  <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      rr_q       <= rr_d;
      noc_din_q  <= noc_din_d;
    end
  end

  assign bus.req_wait_o = ~grant_oh;
  assign bus.noc_wr_o   = (tx_state_q == TX_SEND);
  assign bus.noc_din_o  = noc_din_q;

  // Lowest matching index owns the flit; a full owner blocks the head of the router queue.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_nd_d    = rx_nd_q & ~bus.rx_rd_i;
    rx_dout_d  = rx_dout_q;
    noc_rd     = 1'b0;
    match_oh   = '0;
    h_orig     = bus.noc_dout_i[HO_MSB -: 3];
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (REQ_TGT_ADR[3*i +: 3] == h_orig) begin
        match_oh    = '0;
        match_oh[i] = 1'b1;
      end
    end
    rx_free = |(match_oh & (~rx_nd_q | bus.rx_rd_i));
    if (rx_state_q == RX_GAP) begin
      rx_state_d = RX_IDLE;
    end else if (rst_n_i && bus.noc_nd_i && ((match_oh == '0) || rx_free)) begin
      noc_rd     = 1'b1;
      rx_state_d = RX_GAP;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (match_oh[i]) begin
          rx_nd_d[i]              = 1'b1;
          rx_dout_d[BUS*i +: BUS] = bus.noc_dout_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_state_q <= RX_IDLE;
      rx_nd_q    <= '0;
      rx_dout_q  <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_nd_q    <= rx_nd_d;
      rx_dout_q  <= rx_dout_d;
    end
  end

  assign bus.noc_rd_o  = noc_rd;
  assign bus.rx_nd_o   = rx_nd_q;
  assign bus.rx_dout_o = rx_dout_q;

`ifdef RTSNOC_ARB_STATS_EN
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    tx_cnt_d   = tx_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if ((tx_state_q == TX_SEND) && !bus.noc_wait_i && (tx_cnt_q != 16'hFFFF))
      tx_cnt_d = tx_cnt_q + 16'd1;
    if (noc_rd && (match_oh == '0) && (drop_cnt_q != 16'hFFFF))
      drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      tx_cnt_q   <= tx_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.stat_tx_cnt_o   = tx_cnt_q;
  assign bus.stat_drop_cnt_o = drop_cnt_q;
`else
  assign bus.stat_tx_cnt_o   = '0;
  assign bus.stat_drop_cnt_o = '0;
`endif
endmodule
